// File: rtl/sprite_bram_loader_if.sv
// -----------------------------------------------------------------------------
// sprite_bram_loader_if
//
// Bundles the byte-stream input and the sprite BRAM write ports of the sprite
// loader so that the producer side (host bridge / test bench) and the loader
// connect through one port.
//
//   byte_in, byte_valid  : incoming stream byte and its qualifier
//   byte_ready           : loader accepts a byte this cycle
//   abort                : drop the packet in progress
//   img_addr/data/we     : image-index BRAM write port (AW-bit address, 8-bit data)
//   pal_addr/data/we     : palette BRAM write port (8-bit address, {R,G,B} data)
//   busy, done, chk_ok, err : packet status
//
// Modports:
//   master : the stream producer, which also observes the write and status signals
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface sprite_bram_loader_if #(
  parameter int AW = 17
);
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          abort;

  logic [AW-1:0] img_addr;
  logic [7:0]    img_data;
  logic          img_we;

  logic [7:0]    pal_addr;
  logic [23:0]   pal_data;
  logic          pal_we;

  logic          busy;
  logic          done;
  logic          chk_ok;
  logic          err;

  modport master (
    output byte_in, byte_valid, abort,
    input  byte_ready,
    input  img_addr, img_data, img_we,
    input  pal_addr, pal_data, pal_we,
    input  busy, done, chk_ok, err
  );

  modport slave (
    input  byte_in, byte_valid, abort,
    output byte_ready,
    output img_addr, img_data, img_we,
    output pal_addr, pal_data, pal_we,
    output busy, done, chk_ok, err
  );
endinterface

// File: rtl/sprite_bram_loader.sv
// -----------------------------------------------------------------------------
// sprite_bram_loader
//
// Writer side of the palette-indexed sprite memories. Parses framed load
// packets from a byte stream:
//
//   command byte | payload | checksum byte (XOR of payload bytes)
//
//   0xA0+f (f < FRAMES) : image frame f, WIDTH*HEIGHT index bytes, row-major,
//                         written to img_addr = f*WIDTH*HEIGHT + k
//   0xB0                : palette, 768 bytes as R,G,B for entries 0..255,
//                         one palette write per completed triplet
//   anything else       : ignored in IDLE, err pulses
//
// Ports:
//   pixel_clk : single clock
//   rst       : synchronous active-high reset
//   bus       : sprite_bram_loader_if.slave (stream in, BRAM write ports, status)
//
// All outputs are registered. Write strobes, done and err appear exactly one
// cycle after the edge that accepted the corresponding byte and last one cycle;
// address/data are held after a strobe. The stream is never back-pressured
// except in the cycle following reset.
//
// Frame decode uses the low nibble of the command byte, so FRAMES is limited
// to 16.
// -----------------------------------------------------------------------------
module sprite_bram_loader #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int FRAMES = 2,
  parameter int AW     = $clog2(WIDTH * HEIGHT * FRAMES)
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  sprite_bram_loader_if.slave  bus
);

  localparam int            FRAME_SIZE = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LAST_K     = AW'(FRAME_SIZE - 1);

  localparam logic [7:0] CMD_PAL    = 8'hB0;
  localparam logic [3:0] CMD_IMG_HI = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    IMG,
    PAL,
    CHK
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q,      state_d;
  logic [AW-1:0] base_q,       base_d;      // first address of selected frame
  logic [AW-1:0] cnt_q,        cnt_d;       // payload byte index within frame
  logic [7:0]    xor_q,        xor_d;       // running payload checksum
  logic [1:0]    phase_q,      phase_d;     // 0=R, 1=G, 2=B
  logic [7:0]    entry_q,      entry_d;     // palette entry being assembled
  logic [7:0]    red_q,        red_d;
  logic [7:0]    green_q,      green_d;

  // Registered outputs
  logic          byte_ready_q, byte_ready_d;
  logic [AW-1:0] img_addr_q,   img_addr_d;
  logic [7:0]    img_data_q,   img_data_d;
  logic          img_we_q,     img_we_d;
  logic [7:0]    pal_addr_q,   pal_addr_d;
  logic [23:0]   pal_data_q,   pal_data_d;
  logic          pal_we_q,     pal_we_d;
  logic          busy_q,       busy_d;
  logic          done_q,       done_d;
  logic          chk_ok_q,     chk_ok_d;
  logic          err_q,        err_d;

  // ---------------------------------------------------------------------------
  // Command decode (only meaningful when a byte is accepted in IDLE)
  // ---------------------------------------------------------------------------
  logic accept;
  logic is_img_cmd;
  logic is_pal_cmd;

  assign accept     = bus.byte_valid && byte_ready_q;
  assign is_img_cmd = (bus.byte_in[7:4] == CMD_IMG_HI) &&
                      (int'(bus.byte_in[3:0]) < FRAMES);
  assign is_pal_cmd = (bus.byte_in == CMD_PAL);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d takes a default before any branch (hold for state and
    // data, zero for strobes), so no path leaves it unassigned and no latch
    // is inferred.
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    xor_d        = xor_q;
    phase_d      = phase_q;
    entry_d      = entry_q;
    red_d        = red_q;
    green_d      = green_q;

    byte_ready_d = 1'b1;
    img_addr_d   = img_addr_q;
    img_data_d   = img_data_q;
    img_we_d     = 1'b0;
    pal_addr_d   = pal_addr_q;
    pal_data_d   = pal_data_q;
    pal_we_d     = 1'b0;
    done_d       = 1'b0;
    chk_ok_d     = chk_ok_q;
    err_d        = 1'b0;

    if (bus.abort) begin
      // Abort wins over a simultaneous transfer: the byte is discarded and
      // the packet is dropped without done or err. Writes already issued
      // stay in the BRAM.
      state_d = IDLE;
      cnt_d   = '0;
      xor_d   = '0;
      phase_d = '0;
      entry_d = '0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (is_img_cmd) begin
            state_d  = IMG;
            base_d   = AW'(int'(bus.byte_in[3:0]) * FRAME_SIZE);
            cnt_d    = '0;
            xor_d    = '0;
            chk_ok_d = 1'b0;
          end else if (is_pal_cmd) begin
            state_d  = PAL;
            phase_d  = '0;
            entry_d  = '0;
            xor_d    = '0;
            chk_ok_d = 1'b0;
          end else begin
            err_d    = 1'b1;
          end
        end

        IMG: begin
          img_we_d   = 1'b1;
          img_addr_d = base_q + cnt_q;
          img_data_d = bus.byte_in;
          xor_d      = xor_q ^ bus.byte_in;
          if (cnt_q == LAST_K) begin
            state_d = CHK;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end

        PAL: begin
          xor_d = xor_q ^ bus.byte_in;
          unique case (phase_q)
            2'd0: begin
              red_d   = bus.byte_in;
              phase_d = 2'd1;
            end
            2'd1: begin
              green_d = bus.byte_in;
              phase_d = 2'd2;
            end
            default: begin
              // Blue byte completes the triplet: write the entry now.
              pal_we_d   = 1'b1;
              pal_addr_d = entry_q;
              pal_data_d = {red_q, green_q, bus.byte_in};
              phase_d    = 2'd0;
              entry_d    = entry_q + 8'd1;
              if (entry_q == 8'hFF) begin
                state_d = CHK;
              end
            end
          endcase
        end

        CHK: begin
          chk_ok_d = (bus.byte_in == xor_q);
          done_d   = 1'b1;
          state_d  = IDLE;
          xor_d    = '0;
          phase_d  = '0;
          entry_d  = '0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // busy mirrors the registered state, so it rises the cycle after the
    // command and falls together with done or after abort.
    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixel_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      xor_q        <= '0;
      phase_q      <= '0;
      entry_q      <= '0;
      red_q        <= '0;
      green_q      <= '0;
      byte_ready_q <= 1'b0;
      img_addr_q   <= '0;
      img_data_q   <= '0;
      img_we_q     <= 1'b0;
      pal_addr_q   <= '0;
      pal_data_q   <= '0;
      pal_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      chk_ok_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      phase_q      <= phase_d;
      entry_q      <= entry_d;
      red_q        <= red_d;
      green_q      <= green_d;
      byte_ready_q <= byte_ready_d;
      img_addr_q   <= img_addr_d;
      img_data_q   <= img_data_d;
      img_we_q     <= img_we_d;
      pal_addr_q   <= pal_addr_d;
      pal_data_q   <= pal_data_d;
      pal_we_q     <= pal_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      chk_ok_q     <= chk_ok_d;
      err_q        <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.byte_ready = byte_ready_q;
  assign bus.img_addr   = img_addr_q;
  assign bus.img_data   = img_data_q;
  assign bus.img_we     = img_we_q;
  assign bus.pal_addr   = pal_addr_q;
  assign bus.pal_data   = pal_data_q;
  assign bus.pal_we     = pal_we_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.chk_ok     = chk_ok_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_sprite_bram_loader.sv
// -----------------------------------------------------------------------------
// tb_sprite_bram_loader
//
// Scoreboard bench for sprite_bram_loader with a 4x2, 2-frame image memory.
// Stimulus pushes the expected image writes, palette writes, done/chk_ok
// results and err pulses into queues; a monitor on the falling edge pops and
// compares whenever the loader presents a strobe.
// -----------------------------------------------------------------------------
module tb_sprite_bram_loader;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int FRAMES = 2;
  localparam int AW     = $clog2(WIDTH * HEIGHT * FRAMES);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } img_wr_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] data;
  } pal_wr_t;

  logic pixel_clk = 1'b0;
  logic rst;

  always #5 pixel_clk = ~pixel_clk;

  sprite_bram_loader_if #(.AW(AW)) bus ();

  sprite_bram_loader #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .FRAMES (FRAMES),
    .AW     (AW)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  img_wr_t img_exp[$];
  pal_wr_t pal_exp[$];
  bit      done_exp[$];   // expected chk_ok for each done pulse
  int      err_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: pulse with nothing expected (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge pixel_clk) begin
    img_wr_t ie;
    pal_wr_t pe;
    bit      ok;
    if (bus.img_we === 1'b1) begin
      if (img_exp.size() == 0) unexpected("img_we");
      else begin
        ie = img_exp.pop_front();
        check("img_addr", 32'(bus.img_addr), 32'(ie.addr));
        check("img_data", 32'(bus.img_data), 32'(ie.data));
      end
    end
    if (bus.pal_we === 1'b1) begin
      if (pal_exp.size() == 0) unexpected("pal_we");
      else begin
        pe = pal_exp.pop_front();
        check("pal_addr", 32'(bus.pal_addr), 32'(pe.addr));
        check("pal_data", 32'(bus.pal_data), 32'(pe.data));
      end
    end
    if (bus.done === 1'b1) begin
      if (done_exp.size() == 0) unexpected("done");
      else begin
        ok = done_exp.pop_front();
        check("chk_ok", 32'(bus.chk_ok), 32'(ok));
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
    if (bus.err === 1'b1) begin
      if (err_pending == 0) unexpected("err");
      else begin
        err_pending--;
        check("busy_at_err", 32'(bus.busy), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    while (bus.byte_ready !== 1'b1 && waited < 8) begin
      @(posedge pixel_clk); #1;
      waited++;
    end
    if (bus.byte_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout: ready=%b after %0d cycles", bus.byte_ready, waited);
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(posedge pixel_clk); #1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
  endtask

  // Optional random idle cycles (about 50%) before each byte.
  task automatic send_byte_g(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.byte_in = 8'($urandom);
        @(posedge pixel_clk); #1;
      end
    end
    send_byte(b);
  endtask

  // Image packet: expected writes at frame*8+k; exp_ok is the hand-derived result.
  task automatic send_img(input int frame, input logic [7:0] data [8],
                          input logic [7:0] chk, input bit exp_ok);
    send_byte(8'hA0 + 8'(frame));
    for (int k = 0; k < 8; k++) begin
      img_exp.push_back('{addr: AW'(frame * 8 + k), data: data[k]});
      send_byte(data[k]);
    end
    done_exp.push_back(exp_ok);
    send_byte(chk);
  endtask

  // Palette packet: entry 5 = 12,34,56, all other entries zero, checksum 0x70.
  task automatic send_pal(input bit gaps);
    logic [7:0] r, g, b;
    send_byte_g(8'hB0, gaps);
    for (int e = 0; e < 256; e++) begin
      r = (e == 5) ? 8'h12 : 8'h00;
      g = (e == 5) ? 8'h34 : 8'h00;
      b = (e == 5) ? 8'h56 : 8'h00;
      send_byte_g(r, gaps);
      send_byte_g(g, gaps);
      pal_exp.push_back('{addr: 8'(e), data: {r, g, b}});
      send_byte_g(b, gaps);
    end
    done_exp.push_back(1'b1);
    send_byte_g(8'h70, gaps);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (img_exp.size() == 0 && pal_exp.size() == 0 &&
          done_exp.size() == 0 && err_pending == 0) break;
      @(posedge pixel_clk); #1;
    end
    repeat (3) @(posedge pixel_clk);
    #1;
    check(name, 32'(img_exp.size() + pal_exp.size() + done_exp.size() + err_pending), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.byte_ready, 12'(bus.img_addr), bus.img_data, bus.img_we,
                 bus.pal_addr, bus.busy, bus.done, bus.chk_ok, bus.err, bus.pal_we}, 32'd0);
    check({name, "_pal_data"}, 32'(bus.pal_data), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] seq_data [8];
  logic [7:0] ff_data  [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      seq_data[i] = 8'(i + 1);
      ff_data[i]  = 8'hFF;
    end
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.abort      = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge pixel_clk);
    check("ready_cycle_after_rst", 32'(bus.byte_ready), 32'd0);
    @(posedge pixel_clk); #1;
    check("ready_after_rst", 32'(bus.byte_ready), 32'd1);

    // Frame 1: A1, 01..08, checksum 08 -> addr 8..15.
    send_img(1, seq_data, 8'h08, 1'b1);
    drain("img_frame1_drain");
    check("img_frame1_busy", 32'(bus.busy), 32'd0);

    // Unknown commands: err each, no writes, busy stays low, chk_ok held.
    err_pending++;
    send_byte(8'hA2);
    @(negedge pixel_clk);
    check("unknown_a2_busy", 32'(bus.busy), 32'd0);
    err_pending++;
    send_byte(8'h55);
    drain("unknown_drain");
    check("unknown_chk_ok_held", 32'(bus.chk_ok), 32'd1);

    // Bad checksum on frame 0: writes stand, chk_ok 0. chk_ok clears on the command.
    send_byte(8'hA0);
    @(negedge pixel_clk);
    check("cmd_clears_chk_ok", 32'(bus.chk_ok), 32'd0);
    check("cmd_sets_busy", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      img_exp.push_back('{addr: AW'(k), data: ff_data[k]});
      send_byte(ff_data[k]);
    end
    done_exp.push_back(1'b0);
    send_byte(8'h01);

    // Back-to-back: next command immediately after the checksum, then abort
    // after 4 payload bytes (abort cycle carries a byte that must be dropped).
    send_byte(8'hA0);
    for (int k = 0; k < 4; k++) begin
      img_exp.push_back('{addr: AW'(k), data: seq_data[k]});
      send_byte(seq_data[k]);
    end
    bus.abort      = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h99;
    @(posedge pixel_clk); #1;
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
    drain("abort_drain");
    check("abort_busy", 32'(bus.busy), 32'd0);
    send_img(0, seq_data, 8'h08, 1'b1);
    drain("after_abort_drain");

    // Same with a reset pulse instead of abort.
    send_byte(8'hA0);
    for (int k = 0; k < 4; k++) begin
      img_exp.push_back('{addr: AW'(k), data: seq_data[k]});
      send_byte(seq_data[k]);
    end
    rst = 1'b1;
    @(posedge pixel_clk); #1;
    check_reset_outputs("midpacket_reset");
    rst = 1'b0;
    send_img(0, seq_data, 8'h08, 1'b1);
    drain("after_reset_drain");

    // Palette, gap-free then with random gaps: identical expected sequence.
    send_pal(1'b0);
    drain("pal_drain");
    send_pal(1'b1);
    drain("pal_gaps_drain");
    check("pal_final_chk_ok", 32'(bus.chk_ok), 32'd1);
    check("pal_final_data_held", 32'(bus.pal_data), 32'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
